// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer: steps an external 1-bit ALU slice LSB-first over WIDTH cycles,
// keeping the carry in a register and collecting the slice output in a shift register.
module alu_bitserial_seq #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_ainvert,
  output logic             alu_binvert,
  output logic             alu_cin,
  output logic             alu_less,
  output logic [3:0]       alu_operation,
  input  logic             alu_cout,
  input  logic             alu_result
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_sh, r_result;
  logic [3:0]       r_op;
  logic [IW-1:0]    r_idx;
  logic             r_c, r_zero, r_carry, r_overflow, r_illegal;

  logic             w_legal, w_accept, w_last, w_arith, w_slt, w_set;
  logic [WIDTH-1:0] w_sh_next, w_load;

  always_comb begin
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: w_legal = 1'b1;
      default:                                               w_legal = 1'b0;
    endcase
  end

  // start only counts in IDLE or DONE; a request during RUN is dropped.
  assign w_accept  = start && (r_state != S_RUN);
  assign w_last    = (r_state == S_RUN) && (r_idx == LAST_IDX);
  assign w_arith   = r_op[1];
  assign w_slt     = (r_op[1:0] == 2'b11);
  assign w_sh_next = {alu_result, r_sh[WIDTH-1:1]};
  // Signed less-than: sign of a-b corrected by overflow, folded into one XOR at the MSB.
  assign w_set     = (alu_a ^ alu_ainvert) ^ (alu_b ^ alu_binvert) ^ alu_cout;
  assign w_load    = w_slt ? {{(WIDTH-1){1'b0}}, w_set} : w_sh_next;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start)                 w_state_next = w_legal ? S_RUN : S_DONE;
        else if (r_state == S_DONE) w_state_next = S_IDLE;
      end
      S_RUN:   if (w_last) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_idx      <= '0;
      r_c        <= 1'b0;
      r_sh       <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept && w_legal) begin
      r_a   <= a;
      r_b   <= b;
      r_op  <= op;
      r_idx <= '0;
      r_c   <= op[2];
      r_sh  <= '0;
    end else if (w_accept) begin
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_c  <= alu_cout;
      r_sh <= w_sh_next;
      if (w_last) begin
        r_result   <= w_load;
        r_zero     <= (w_load == '0);
        r_carry    <= w_arith & alu_cout;
        r_overflow <= w_arith & (r_c ^ alu_cout);
        r_illegal  <= 1'b0;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign illegal  = r_illegal;
  assign alu_less = 1'b0;

  always_comb begin
    alu_a         = 1'b0;
    alu_b         = 1'b0;
    alu_ainvert   = 1'b0;
    alu_binvert   = 1'b0;
    alu_cin       = 1'b0;
    alu_operation = 4'b0000;
    if (r_state == S_RUN) begin
      alu_a         = r_a[r_idx];
      alu_b         = r_b[r_idx];
      alu_ainvert   = r_op[3];
      alu_binvert   = r_op[2];
      alu_cin       = r_c;
      alu_operation = {1'b0, r_op[1:0], r_op[2]};
    end
  end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Bench for alu_bitserial_seq: models the 1-bit slice, runs a vector table and
// hand-written sequences for reset abort, back-to-back illegal start and start-while-busy.
module tb_alu_bitserial_seq;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, carry, overflow, illegal;
  logic [W-1:0] result;
  logic         alu_a, alu_b, alu_ainvert, alu_binvert, alu_cin, alu_less;
  logic [3:0]   alu_operation;
  logic         alu_cout, alu_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .illegal(illegal), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ainvert(alu_ainvert), .alu_binvert(alu_binvert), .alu_cin(alu_cin),
    .alu_less(alu_less), .alu_operation(alu_operation), .alu_cout(alu_cout),
    .alu_result(alu_result)
  );

  // Slice model: Sel = operation[2:1]; 00 AND, 01 OR, 10 ADD, 11 LESS.
  logic w_ao, w_bo;
  always_comb begin
    w_ao     = alu_a ^ alu_ainvert;
    w_bo     = alu_b ^ alu_binvert;
    alu_cout = (w_ao & w_bo) | (w_ao & alu_cin) | (w_bo & alu_cin);
    case (alu_operation[2:1])
      2'b00:   alu_result = w_ao & w_bo;
      2'b01:   alu_result = w_ao | w_bo;
      2'b10:   alu_result = w_ao ^ w_bo ^ alu_cin;
      default: alu_result = alu_less;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues start on one edge, then waits for done; returns cycles to done and busy-cycle count.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (n == 1 && busy) check("alu_operation", 32'(alu_operation), 32'({1'b0, o[1:0], o[2]}));
      if (done) begin lat = n; break; end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic         z, c, v;
  } vec_t;

  vec_t vecs[11];
  int   lat, bcnt;

  initial begin
    vecs[0]  = '{"add_wrap", 4'b0010, 24'h000001, 24'hFFFFFF, 24'h000000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{"sub_ovf",  4'b0110, 24'h800000, 24'h000001, 24'h7FFFFF, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{"slt_lt",   4'b0111, 24'hFFFFFF, 24'h000001, 24'h000001, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"slt_ge",   4'b0111, 24'h000001, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"nor",      4'b1100, 24'h0F0F0F, 24'h00FF00, 24'hF000F0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"and",      4'b0000, 24'h0F0F0F, 24'h00FF00, 24'h000F00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"or",       4'b0001, 24'h0F0F0F, 24'h00FF00, 24'h0FFF0F, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"add_ovf",  4'b0010, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{"sub_zero", 4'b0110, 24'h000005, 24'h000005, 24'h000000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{"slt_ovf",  4'b0111, 24'h800000, 24'h7FFFFF, 24'h000001, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{"slt_eq",   4'b0111, 24'h000003, 24'h000003, 24'h000000, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b1; op = 4'b0010; a = '1; b = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags",  32'({zero, carry, overflow, illegal}), 32'd0);
    check("rst_alu",    32'({alu_a, alu_b, alu_ainvert, alu_binvert, alu_cin, alu_less, alu_operation}), 32'd0);
    reset = 1'b0; start = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(W + 1));
      check({vecs[i].name, "_busy"},    32'(bcnt), 32'(W));
      check({vecs[i].name, "_result"},  32'(result), 32'(vecs[i].res));
      check({vecs[i].name, "_zero"},    32'(zero), 32'(vecs[i].z));
      check({vecs[i].name, "_carry"},   32'(carry), 32'(vecs[i].c));
      check({vecs[i].name, "_ovf"},     32'(overflow), 32'(vecs[i].v));
      check({vecs[i].name, "_illegal"}, 32'(illegal), 32'd0);
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_held",    32'(result), 32'h000000);

    // Illegal op from IDLE: straight to DONE with result cleared.
    run_op(4'b0011, 24'h123456, 24'h654321, lat, bcnt);
    check("ill_latency", 32'(lat), 32'd1);
    check("ill_flags",   32'({illegal, zero, carry, overflow}), 32'b1100);
    check("ill_result",  32'(result), 32'd0);

    // Reset at RUN bit 10 aborts the op and clears the prior result.
    run_op(4'b0001, 24'h0F0F0F, 24'h00FF00, lat, bcnt);
    @(negedge clk);
    start = 1'b1; op = 4'b0010; a = 24'h000123; b = 24'h000456;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    reset = 1'b0;
    bcnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done || busy) bcnt++;
    end
    check("abort_no_done", 32'(bcnt), 32'd0);
    run_op(4'b0010, 24'h000123, 24'h000456, lat, bcnt);
    check("after_abort_lat", 32'(lat), 32'(W + 1));
    check("after_abort_res", 32'(result), 32'h000579);

    // start held through RUN (op changed to illegal) is ignored; still high in DONE -> DONE again, illegal.
    @(negedge clk);
    start = 1'b1; op = 4'b0010; a = 24'h000001; b = 24'h000002;
    @(posedge clk);
    #1 op = 4'b0101; a = 24'hFFFFFF;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    check("held_latency", 32'(lat), 32'(W + 1));
    check("held_result",  32'(result), 32'h000003);
    @(negedge clk);
    check("b2b_done",    32'(done), 32'd1);
    check("b2b_illegal", 32'(illegal), 32'd1);
    check("b2b_result",  32'(result), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("b2b_to_idle", 32'({done, busy}), 32'd0);

    // A legal start pulse mid-RUN does not disturb the running op.
    @(negedge clk);
    start = 1'b1; op = 4'b0110; a = 24'h000010; b = 24'h000003;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 4'b0010; a = 24'h111111; b = 24'h222222;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int n = 7; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    check("pulse_latency", 32'(lat), 32'(W + 1));
    check("pulse_result",  32'(result), 32'h00000D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
